// File: rtl/clk_div_gen.sv
// Multi-channel clock divider / strobe generator with per-channel divisor reload,
// drain-on-disable and optional global phase sync (enabled by CLK_GEN_SYNC_EN).
module clk_div_gen #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*CNT_W-1:0] div_cfg,
  input  logic                 cfg_load,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 sync,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       stb,
  output logic [NCH-1:0]       ch_active,
  output logic                 cfg_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  logic [NCH-1:0] pend_v;

  assign cfg_busy = |pend_v;

`ifndef CLK_GEN_SYNC_EN
  logic sync_unused;
  assign sync_unused = sync;
`endif

  // Divisors 0 and 1 run as 2 so every period has a high and a low phase.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // One extra bit keeps ceil(D/2) exact at the top of the divisor range.
  function automatic logic [CNT_W:0] half_div(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] e;
    e = {1'b0, eff_div(d)};
    return (e + 1'b1) >> 1;
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e        state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [CNT_W-1:0] div_q, div_nx;
    logic [CNT_W-1:0] pend_q, pend_nx;
    logic             pend_v_q, pend_v_nx;
    logic             apply, wrap, restart, sync_hit;
    logic             active_nx, clk_nx, stb_nx;
    logic             clk_q, stb_q, active_q;

    always_comb begin
      sync_hit = 1'b0;
`ifdef CLK_GEN_SYNC_EN
      sync_hit = sync && (state_q != ST_IDLE);
`endif
      wrap     = (state_q != ST_IDLE) && (cnt_q == eff_div(div_q) - CNT_W'(1));
      restart  = wrap || sync_hit;
      state_nx = state_q;
      cnt_nx   = cnt_q;
      apply    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_nx = '0;
          apply  = pend_v_q;
          if (ch_en[i]) state_nx = ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (restart) begin
            // A sync seen while draining ends the drain immediately.
            cnt_nx   = '0;
            apply    = pend_v_q;
            state_nx = (ch_en[i] && !(state_q == ST_DRAIN && sync_hit)) ? ST_RUN : ST_IDLE;
          end else begin
            cnt_nx   = cnt_q + CNT_W'(1);
            state_nx = ch_en[i] ? ST_RUN : ST_DRAIN;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      endcase
      div_nx    = apply ? pend_q : div_q;
      // A load landing on an apply cycle stays pending: apply consumes the old value.
      pend_nx   = cfg_load ? div_cfg[i*CNT_W +: CNT_W] : pend_q;
      pend_v_nx = cfg_load | (pend_v_q & ~apply);
      active_nx = (state_nx != ST_IDLE);
      clk_nx    = active_nx && ({1'b0, cnt_nx} < half_div(div_nx));
      stb_nx    = active_nx && (cnt_nx == eff_div(div_nx) - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        div_q    <= CNT_W'(DIV_DEFAULT);
        pend_q   <= '0;
        pend_v_q <= 1'b0;
        clk_q    <= 1'b0;
        stb_q    <= 1'b0;
        active_q <= 1'b0;
      end else begin
        state_q  <= state_nx;
        cnt_q    <= cnt_nx;
        div_q    <= div_nx;
        pend_q   <= pend_nx;
        pend_v_q <= pend_v_nx;
        clk_q    <= clk_nx;
        stb_q    <= stb_nx;
        active_q <= active_nx;
      end
    end

    assign clk_out[i]   = clk_q;
    assign stb[i]       = stb_q;
    assign ch_active[i] = active_q;
    assign pend_v[i]    = pend_v_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen (NCH=2, CNT_W=8); sync expectations follow CLK_GEN_SYNC_EN.
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div_cfg;
  logic        cfg_load;
  logic [1:0]  ch_en;
  logic        sync;
  logic [1:0]  clk_out, stb, ch_active;
  logic        cfg_busy;

  int total = 0;
  int bad   = 0;

  clk_div_gen #(.NCH(2), .CNT_W(8), .DIV_DEFAULT(4)) dut (
    .clk(clk), .rst_n(rst_n), .div_cfg(div_cfg), .cfg_load(cfg_load),
    .ch_en(ch_en), .sync(sync), .clk_out(clk_out), .stb(stb),
    .ch_active(ch_active), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_en = '0; cfg_load = 1'b0; sync = 1'b0; div_cfg = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    step();
    total++;
    if ({clk_out, stb, ch_active, cfg_busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {clk_out, stb, ch_active, cfg_busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:0] e_clk, e_stb;
    do_reset();
    ch_en = 2'b01;
    step();
    for (int k = 0; k < 12; k++) begin
      e_clk = {1'b0, (k % 4) < 2};
      e_stb = {1'b0, (k % 4) == 3};
      total++;
      if (clk_out !== e_clk || stb !== e_stb || ch_active !== 2'b01) begin
        bad++;
        $display("FAIL basic k=%0d got clk=%b stb=%b act=%b exp clk=%b stb=%b act=01",
                 k, clk_out, stb, ch_active, e_clk, e_stb);
      end
      step();
    end
  endtask

  task automatic test_reload();
    logic e_clk, e_stb, e_busy;
    int j;
    do_reset();
    ch_en = 2'b01;
    step();
    step();
    cfg_load = 1'b1;
    div_cfg  = {8'd4, 8'd5};
    total++;
    if (cfg_busy !== 1'b0) begin
      bad++;
      $display("FAIL reload_busy_before got=%b exp=0", cfg_busy);
    end
    step();
    cfg_load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k < 2) begin
        e_clk = 1'b0;
        e_stb = (k == 1);
        e_busy = 1'b1;
      end else begin
        j = (k - 2) % 5;
        e_clk = (j < 3);
        e_stb = (j == 4);
        e_busy = 1'b0;
      end
      total++;
      if (clk_out[0] !== e_clk || stb[0] !== e_stb || cfg_busy !== e_busy) begin
        bad++;
        $display("FAIL reload k=%0d got clk=%b stb=%b busy=%b exp clk=%b stb=%b busy=%b",
                 k, clk_out[0], stb[0], cfg_busy, e_clk, e_stb, e_busy);
      end
      step();
    end
  endtask

  task automatic test_disable();
    logic [2:0] got;
    logic [2:0] exp_v [4];
    exp_v[0] = 3'b001; exp_v[1] = 3'b011; exp_v[2] = 3'b000; exp_v[3] = 3'b000;
    do_reset();
    ch_en = 2'b01;
    step();
    step();
    ch_en = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      got = {clk_out[0], stb[0], ch_active[0]};
      total++;
      if (got !== exp_v[k]) begin
        bad++;
        $display("FAIL disable k=%0d got {clk,stb,act}=%b exp=%b", k, got, exp_v[k]);
      end
    end
  endtask

  task automatic test_reenable();
    logic [2:0] got;
    logic [2:0] exp_v [5];
    exp_v[0] = 3'b001; exp_v[1] = 3'b011; exp_v[2] = 3'b101;
    exp_v[3] = 3'b101; exp_v[4] = 3'b001;
    do_reset();
    ch_en = 2'b01;
    step();
    step();
    ch_en = 2'b00;
    step();
    ch_en = 2'b01;
    for (int k = 0; k < 5; k++) begin
      got = {clk_out[0], stb[0], ch_active[0]};
      total++;
      if (got !== exp_v[k]) begin
        bad++;
        $display("FAIL reenable k=%0d got {clk,stb,act}=%b exp=%b", k, got, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_min_div();
    logic [1:0] e_clk, e_stb;
    do_reset();
    div_cfg  = {8'd1, 8'd0};
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    total++;
    if (cfg_busy !== 1'b1) begin
      bad++;
      $display("FAIL min_div_busy_rise got=%b exp=1", cfg_busy);
    end
    step();
    total++;
    if (cfg_busy !== 1'b0) begin
      bad++;
      $display("FAIL min_div_busy_fall got=%b exp=0", cfg_busy);
    end
    ch_en = 2'b11;
    step();
    for (int k = 0; k < 6; k++) begin
      e_clk = (k % 2 == 0) ? 2'b11 : 2'b00;
      e_stb = (k % 2 == 0) ? 2'b00 : 2'b11;
      total++;
      if (clk_out !== e_clk || stb !== e_stb) begin
        bad++;
        $display("FAIL min_div k=%0d got clk=%b stb=%b exp clk=%b stb=%b",
                 k, clk_out, stb, e_clk, e_stb);
      end
      step();
    end
  endtask

  task automatic test_sync();
    logic [1:0] e_clk [2];
    logic [1:0] e_stb [2];
`ifdef CLK_GEN_SYNC_EN
    e_clk[0] = 2'b11; e_stb[0] = 2'b00;
    e_clk[1] = 2'b11; e_stb[1] = 2'b00;
`else
    e_clk[0] = 2'b00; e_stb[0] = 2'b11;
    e_clk[1] = 2'b11; e_stb[1] = 2'b00;
`endif
    do_reset();
    div_cfg  = {8'd6, 8'd4};
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
    ch_en = 2'b10;
    step();
    step();
    ch_en = 2'b11;
    step();
    step();
    step();
    total++;
    if (clk_out !== 2'b00 || stb !== 2'b00) begin
      bad++;
      $display("FAIL sync_pre got clk=%b stb=%b exp clk=00 stb=00", clk_out, stb);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (clk_out !== e_clk[k] || stb !== e_stb[k]) begin
        bad++;
        $display("FAIL sync k=%0d got clk=%b stb=%b exp clk=%b stb=%b",
                 k, clk_out, stb, e_clk[k], e_stb[k]);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    logic e_clk, e_stb;
    do_reset();
    ch_en = 2'b01;
    step();
    step();
    cfg_load = 1'b1;
    div_cfg  = {8'd4, 8'd5};
    step();
    cfg_load = 1'b0;
    total++;
    if (cfg_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_busy got=%b exp=1", cfg_busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({clk_out, stb, ch_active, cfg_busy} !== 7'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%b exp=0", {clk_out, stb, ch_active, cfg_busy});
    end
    step();
    for (int k = 0; k < 8; k++) begin
      e_clk = (k % 4) < 2;
      e_stb = (k % 4) == 3;
      total++;
      if (clk_out[0] !== e_clk || stb[0] !== e_stb || ch_active[0] !== 1'b1) begin
        bad++;
        $display("FAIL mid_reset_div k=%0d got clk=%b stb=%b act=%b exp clk=%b stb=%b act=1",
                 k, clk_out[0], stb[0], ch_active[0], e_clk, e_stb);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_disable();
    test_reenable();
    test_min_div();
    test_sync();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
